// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  // Operand/result width; the sequencer runs one iteration per bit.
  localparam int XLEN = 32;

  // Divide-by-zero quotient and the most negative signed value.
  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  // funct3 encodings of the M extension.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle datapath: a shift-add multiply step or a
// restoring divide step. Purely combinational; the controller registers it.
//
// Register roles:
//   multiply: acc = partial product, opa = multiplicand shifted left each
//             step, opb = multiplier shifted right each step.
//   divide:   acc = {remainder, quotient}, opa[XLEN-1] supplies the next
//             dividend bit (opa shifts left), opb = divisor (held).
module muldiv_step import muldiv_pkg::*; (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [2*XLEN-1:0] opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [2*XLEN-1:0] opa_nxt,
  output logic [XLEN-1:0]   opb_nxt
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            unused_diff_bit;

  // The remainder is always below the divisor, so after a successful trial
  // subtract bit XLEN of the difference is zero and can be dropped.
  assign unused_diff_bit = diff[XLEN];

  // Single iteration of either algorithm.
  always_comb begin
    shifted = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opb};
    opa_nxt = opa << 1;
    opb_nxt = opb;
    acc_nxt = acc;
    if (is_div) begin
      if (diff[XLEN+1]) begin
        acc_nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end else begin
      opb_nxt = opb >> 1;
      if (opb[0]) begin
        acc_nxt = acc + opa;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
// Captures operands on start, iterates one bit per cycle, holds EX via stall
// and returns Result with a one-cycle done pulse.
//
// Handshake: start is a level request sampled only in IDLE (flush wins);
// the operation is accepted on the edge where start=1 and flush=0 in IDLE.
// stall stays high from that cycle until DONE; done=1 for exactly the cycle
// in which Result is first valid, and Result then holds until the next done.
module muldiv_ctrl import muldiv_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result,
  output muldiv_state_e   state_dbg
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  muldiv_state_e     state, state_nxt;
  muldiv_op_e        op;
  logic [2*XLEN-1:0] opa, acc;
  logic [XLEN-1:0]   opb;
  logic [CW-1:0]     cnt;
  logic              neg_q, neg_r;

  logic              is_div, is_rem, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_raw, a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_val, fix_val, res_val, quo, rem;
  logic [2*XLEN-1:0] prod;
  logic              res_load;
  logic [2*XLEN-1:0] acc_nxt, opa_nxt;
  logic [XLEN-1:0]   opb_nxt;

  assign state_dbg = state;

  // stall is forced low while reset is asserted, even if start is high.
  assign stall = reset & (((state == IDLE) & start & ~flush) | busy);

  muldiv_step u_step (
    .is_div  (is_div),
    .acc     (acc),
    .opa     (opa),
    .opb     (opb),
    .acc_nxt (acc_nxt),
    .opa_nxt (opa_nxt),
    .opb_nxt (opb_nxt)
  );

  // Operand decode, sign handling, special cases and final result select.
  always_comb begin
    is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_rem   = op inside {OP_REM, OP_REMU};
    a_sgn    = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn    = op inside {OP_MULH, OP_DIV, OP_REM};
    // In PREP opa still holds the raw, zero-extended rs1 value.
    a_raw    = opa[XLEN-1:0];
    a_neg    = a_sgn & a_raw[XLEN-1];
    b_neg    = b_sgn & opb[XLEN-1];
    a_mag    = a_neg ? -a_raw : a_raw;
    b_mag    = b_neg ? -opb : opb;
    div_zero = is_div && (opb == '0);
    div_ovf  = (op inside {OP_DIV, OP_REM}) && (a_raw == INT_MIN) && (opb == DIV_ZERO_Q);
    special_val = '0;
    if (div_zero) begin
      special_val = is_rem ? a_raw : DIV_ZERO_Q;
    end else if (div_ovf) begin
      special_val = is_rem ? '0 : INT_MIN;
    end
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                        fix_val = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_val = quo;
      default:                       fix_val = rem;
    endcase
  end

  // Next-state logic and Result load decision; flush overrides everything.
  always_comb begin
    state_nxt = state;
    res_load  = 1'b0;
    res_val   = '0;
    case (state)
      IDLE: if (start && !flush) state_nxt = PREP;
      PREP: begin
        if (div_zero || div_ovf) begin
          state_nxt = DONE;
          res_load  = 1'b1;
          res_val   = special_val;
        end else begin
          state_nxt = CALC;
        end
      end
      CALC: if (cnt == LAST) state_nxt = FIX;
      FIX: begin
        state_nxt = DONE;
        res_load  = 1'b1;
        res_val   = fix_val;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      res_load  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered status outputs and Result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
    end else begin
      busy <= state_nxt inside {PREP, CALC, FIX};
      done <= (state_nxt == DONE);
      if (res_load) Result <= res_val;
    end
  end

  // Operand capture, magnitude formation and per-cycle iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op    <= OP_MUL;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op  <= muldiv_op_e'(funct3);
            opa <= {{XLEN{1'b0}}, SrcA};
            opb <= SrcB;
          end
        end
        PREP: begin
          opa   <= {{XLEN{1'b0}}, a_mag};
          opb   <= b_mag;
          acc   <= '0;
          cnt   <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
        CALC: begin
          acc <= acc_nxt;
          opa <= opa_nxt;
          opb <= opb_nxt;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: cycle-accurate latency, arithmetic results,
// special cases, flush, async reset and start handling.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic          clk = 1'b0;
  logic          reset, start, flush;
  logic [2:0]    funct3;
  logic [31:0]   srca, srcb;
  logic          stall, busy, done;
  logic [31:0]   result;
  muldiv_state_e state_dbg;

  int errors = 0;
  int checks = 0;

  // Clock.
  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .SrcA      (srca),
    .SrcB      (srcb),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .Result    (result),
    .state_dbg (state_dbg)
  );

  // Driver: issue one op (start for one cycle, then garbage operands) and
  // report the cycle of the done pulse (-1 on timeout) and the Result there.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int dc, output logic [31:0] r);
    int cyc;
    @(negedge clk);
    start = 1'b1; funct3 = f; srca = a; srcb = b;
    #1;
    cyc = 0; dc = -1; r = 'x;
    while (cyc < 60) begin
      if (done === 1'b1) begin
        dc = cyc; r = result;
        break;
      end
      @(negedge clk);
      start = 1'b0; srca = $urandom; srcb = $urandom; funct3 = 3'($urandom_range(0, 7));
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_timing();
    logic es, eb, ed;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; srca = 32'd7; srcb = 32'hFFFF_FFFD;
    #1;
    for (int cyc = 0; cyc <= 36; cyc++) begin
      es = (cyc <= 34); eb = (cyc >= 1 && cyc <= 34); ed = (cyc == 35);
      checks++; if (stall !== es) begin errors++; $display("FAIL mul_stall c%0d: got %b expected %b", cyc, stall, es); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL mul_busy c%0d: got %b expected %b", cyc, busy, eb); end
      checks++; if (done !== ed) begin errors++; $display("FAIL mul_done c%0d: got %b expected %b", cyc, done, ed); end
      if (cyc == 35) begin
        checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h expected ffffffeb", result); end
      end
      @(negedge clk);
      start = 1'b0; srca = $urandom; srcb = $urandom; funct3 = 3'($urandom_range(0, 7));
      #1;
    end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f  [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] ex [3] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int dc; logic [31:0] r;
    for (int i = 0; i < 3; i++) begin
      do_op(f[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, r);
      checks++; if (dc !== 35) begin errors++; $display("FAIL mulh_lat f%0d: got %0d expected 35", f[i], dc); end
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL mulh_res f%0d: got %h expected %h", f[i], r, ex[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_0002};
    int dc; logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], dc, r);
      checks++; if (dc !== 35) begin errors++; $display("FAIL div_lat %0d: got %0d expected 35", i, dc); end
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL div_res %0d: got %h expected %h", i, r, ex[i]); end
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f  [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] a  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    int dc; logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], dc, r);
      checks++; if (dc !== 2) begin errors++; $display("FAIL special_lat %0d: got %0d expected 2", i, dc); end
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL special_res %0d: got %h expected %h", i, r, ex[i]); end
    end
  endtask

  task automatic test_flush();
    int dc; logic [31:0] r; logic saw_done;
    do_op(3'b101, 32'd100, 32'd7, dc, r);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL flush_pre: got %h expected 0000000e", r); end
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; srca = 32'd3; srcb = 32'd5;
    #1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk); start = 1'b0; #1;
    end
    checks++; if (state_dbg !== CALC) begin errors++; $display("FAIL flush_in_calc: got %0d expected %0d", state_dbg, CALC); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL flush_state: got %0d expected %0d", state_dbg, IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0) saw_done = 1'b1;
      @(negedge clk); #1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", saw_done); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result_hold: got %h expected 0000000e", result); end
    do_op(3'b101, 32'd9, 32'd3, dc, r);
    checks++; if (dc !== 35) begin errors++; $display("FAIL flush_after_lat: got %0d expected 35", dc); end
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL flush_after_res: got %h expected 00000003", r); end
  endtask

  task automatic test_async_reset();
    int dc; logic [31:0] r;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; srca = 32'd6; srcb = 32'd7;
    #1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); start = 1'b0; #1;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", busy); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL areset_result: got %h expected 00000000", result); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL areset_state: got %0d expected %0d", state_dbg, IDLE); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL areset_release_state: got %0d expected %0d", state_dbg, IDLE); end
    do_op(3'b000, 32'd6, 32'd7, dc, r);
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL areset_after_res: got %h expected 0000002a", r); end
  endtask

  task automatic test_start_held();
    int dc;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; srca = 32'd2; srcb = 32'd3;
    #1;
    dc = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (done === 1'b1) begin dc = cyc; break; end
      @(negedge clk); #1;
    end
    checks++; if (dc !== 35) begin errors++; $display("FAIL held_lat: got %0d expected 35", dc); end
    checks++; if (result !== 32'd6) begin errors++; $display("FAIL held_res: got %h expected 00000006", result); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy_after_done: got %b expected 0", busy); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL held_state_after_done: got %0d expected %0d", state_dbg, IDLE); end
    start = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy_later: got %b expected 0", busy); end
  endtask

  task automatic test_start_flush();
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b100; srca = 32'd5; srcb = 32'd0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sf_stall: got %b expected 0", stall); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL sf_state: got %0d expected %0d", state_dbg, IDLE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sf_busy: got %b expected 0", busy); end
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sf_done: got %b expected 0", done); end
  endtask

  // Reset, then every scenario in sequence, then the summary.
  initial begin
    reset = 1'b0; start = 1'b1; flush = 1'b0;
    funct3 = 3'b000; srca = 32'h0; srcb = 32'h0;
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_div();
    test_div_special();
    test_flush();
    test_async_reset();
    test_start_held();
    test_start_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
